// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver with configurable data width, parity and stop bits.
// Each bit is decided by a 2-of-3 majority vote around mid-bit. Parity, framing and overrun
// errors are reported alongside the delivered word.
//
// Output handshake: o_data_valid rises the cycle after a frame completes. From then on,
// o_data, o_parity_err and o_frame_err stay stable until a cycle in which o_data_valid
// and i_data_ready are both high. That cycle is the transfer. A frame that completes
// while a word is held and not being accepted is dropped, and o_overrun pulses for one cycle.
module uart_rx_cfg #(
    parameter int I_CLK_FREQ  = 27_000_000,
    parameter int BAUDRATE    = 115200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int COUNTER_LEN = 12
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_data,
    input  logic                 i_data_ready,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_data_valid,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_busy
);

    localparam int COUNT_MAX = I_CLK_FREQ / BAUDRATE;
    localparam int MID       = COUNT_MAX >> 1;
    localparam int IDX_W     = $clog2(DATA_BITS);

    localparam logic [COUNTER_LEN-1:0] T_LAST = COUNTER_LEN'(COUNT_MAX - 1);
    localparam logic [COUNTER_LEN-1:0] T_S0   = COUNTER_LEN'(MID - 1);
    localparam logic [COUNTER_LEN-1:0] T_S1   = COUNTER_LEN'(MID);
    localparam logic [COUNTER_LEN-1:0] T_S2   = COUNTER_LEN'(MID + 1);
    localparam logic [IDX_W-1:0]       IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic                   STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t                 state;
    logic [1:0]             sync_q;
    logic                   rx_prev;
    logic [COUNTER_LEN-1:0] timer;
    logic                   samp_a;
    logic                   samp_b;
    logic [IDX_W-1:0]       bit_idx;
    logic                   stop_idx;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   par_err_q;
    logic                   frm_err_q;
    logic                   busy_q;

    logic rx;
    logic maj;
    logic at_sample;
    logic fall;
    logic frame_done;
    logic frame_err_now;
    logic par_calc;

    // Majority vote, sample strobe, edge detect and end-of-frame decode
    always_comb begin
        rx            = sync_q[1];
        maj           = (samp_a & samp_b) | (samp_a & rx) | (samp_b & rx);
        at_sample     = (timer == T_S2);
        fall          = rx_prev & ~rx;
        frame_done    = (state == S_STOP) && at_sample && (stop_idx == STOP_LAST);
        frame_err_now = frm_err_q | ~maj;
        if (PARITY == 1) begin
            par_calc = ~(^shift_q ^ maj);
        end else begin
            par_calc = ^shift_q ^ maj;
        end
    end

    // Two-flop synchroniser plus previous-value flop for falling-edge detection; idle line is high
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q  <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            sync_q  <= {sync_q[0], i_data};
            rx_prev <= sync_q[1];
        end
    end

    // Bit timer: parked at 0 while waiting for a start bit, otherwise free-runs modulo COUNT_MAX
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            timer <= '0;
        end else if (state == S_IDLE || state == S_WAIT_HIGH || timer == T_LAST) begin
            timer <= '0;
        end else begin
            timer <= timer + COUNTER_LEN'(1);
        end
    end

    // Capture the first two of the three mid-bit samples; the third is the live line
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            samp_a <= 1'b1;
            samp_b <= 1'b1;
        end else begin
            if (timer == T_S0) samp_a <= rx;
            if (timer == T_S1) samp_b <= rx;
        end
    end

    // Frame FSM: start qualification, data shift, parity and stop checks, break wait
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= S_IDLE;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            shift_q   <= '0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fall) begin
                        state  <= S_START;
                        busy_q <= 1'b1;
                    end
                end
                S_START: begin
                    if (at_sample) begin
                        if (maj) begin
                            state  <= S_IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            state     <= S_DATA;
                            bit_idx   <= '0;
                            par_err_q <= 1'b0;
                            frm_err_q <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (at_sample) begin
                        shift_q <= {maj, shift_q[DATA_BITS-1:1]};
                        if (bit_idx == IDX_LAST) begin
                            state    <= (PARITY != 0) ? S_PARITY : S_STOP;
                            stop_idx <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (at_sample) begin
                        par_err_q <= par_calc;
                        state     <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (at_sample) begin
                        frm_err_q <= frame_err_now;
                        if (stop_idx == STOP_LAST) begin
                            // A line still low here is a break: hold off start detection until it rises
                            state  <= rx ? S_IDLE : S_WAIT_HIGH;
                            busy_q <= ~rx;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end
                S_WAIT_HIGH: begin
                    if (rx) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Output word register: load on completion, clear on acceptance, flag a dropped frame
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data       <= '0;
            o_data_valid <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_overrun <= 1'b0;
            if (frame_done) begin
                if (!o_data_valid || i_data_ready) begin
                    o_data       <= shift_q;
                    o_parity_err <= par_err_q;
                    o_frame_err  <= frame_err_now;
                    o_data_valid <= 1'b1;
                end else begin
                    o_overrun <= 1'b1;
                end
            end else if (o_data_valid && i_data_ready) begin
                o_data_valid <= 1'b0;
                o_parity_err <= 1'b0;
                o_frame_err  <= 1'b0;
            end
        end
    end

    assign o_busy = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three instances share one serial line.
//   A: 8N1
//   B: 7 data bits, even parity, 1 stop bit
//   C: 9 data bits, odd parity, 2 stop bits
// Bit period is 40 clocks.
module tb_uart_rx_cfg;

  localparam int CM   = 40;
  localparam int MIDP = CM / 2;

  int cfg_bits[3] = '{8, 7, 9};
  int cfg_par[3]  = '{0, 2, 1};
  int cfg_stop[3] = '{1, 1, 2};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic line = 1'b1;
  logic ready = 1'b1;

  logic [7:0] a_data; logic a_valid, a_perr, a_ferr, a_ovr, a_busy;
  logic [6:0] b_data; logic b_valid, b_perr, b_ferr, b_ovr, b_busy;
  logic [8:0] c_data; logic c_valid, c_perr, c_ferr, c_ovr, c_busy;

  // clock / reset block
  always #5 clk = ~clk;

  uart_rx_cfg #(.I_CLK_FREQ(4_000_000), .BAUDRATE(100_000), .DATA_BITS(8), .PARITY(0),
                .STOP_BITS(1), .COUNTER_LEN(12)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(line), .i_data_ready(ready),
    .o_data(a_data), .o_data_valid(a_valid), .o_parity_err(a_perr),
    .o_frame_err(a_ferr), .o_overrun(a_ovr), .o_busy(a_busy));

  uart_rx_cfg #(.I_CLK_FREQ(4_000_000), .BAUDRATE(100_000), .DATA_BITS(7), .PARITY(2),
                .STOP_BITS(1), .COUNTER_LEN(12)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(line), .i_data_ready(ready),
    .o_data(b_data), .o_data_valid(b_valid), .o_parity_err(b_perr),
    .o_frame_err(b_ferr), .o_overrun(b_ovr), .o_busy(b_busy));

  uart_rx_cfg #(.I_CLK_FREQ(4_000_000), .BAUDRATE(100_000), .DATA_BITS(9), .PARITY(1),
                .STOP_BITS(2), .COUNTER_LEN(12)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(line), .i_data_ready(ready),
    .o_data(c_data), .o_data_valid(c_valid), .o_parity_err(c_perr),
    .o_frame_err(c_ferr), .o_overrun(c_ovr), .o_busy(c_busy));

  // scoreboard state; a word is {parity_err, frame_err, data zero-extended to 9 bits}
  int n_cmp = 0;
  int n_err = 0;
  logic [10:0] exp_q[$];
  logic [10:0] got_q[$];
  int got_rd = 0;
  int sel = -1;
  int ovr_a = 0;
  int valid_a_cnt = 0;

  // monitor: collects accepted words from the selected instance
  always @(negedge clk) begin
    if (a_ovr) ovr_a <= ovr_a + 1;
    if (a_valid) valid_a_cnt <= valid_a_cnt + 1;
    case (sel)
      0: if (a_valid && ready) got_q.push_back({a_perr, a_ferr, 1'b0, a_data});
      1: if (b_valid && ready) got_q.push_back({b_perr, b_ferr, 2'b00, b_data});
      2: if (c_valid && ready) got_q.push_back({c_perr, c_ferr, c_data});
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // driver: hold the line at v for n clock cycles, changing it on falling edges
  task automatic hold(input logic v, input int n);
    repeat (n) begin
      @(negedge clk);
      line = v;
    end
  endtask

  function automatic logic correct_par(input int d, input logic [8:0] data);
    int ones = 0;
    for (int i = 0; i < cfg_bits[d]; i++) ones += int'(data[i]);
    if (cfg_par[d] == 2) return (ones % 2) == 1;
    return (ones % 2) == 0;
  endfunction

  // reference model: the word a receiver of config d must deliver for one sent frame
  function automatic logic [10:0] model(input int d, input logic [8:0] data, input logic flip,
                                         input logic [1:0] stops);
    logic [8:0] mask = 9'((1 << cfg_bits[d]) - 1);
    logic perr = (cfg_par[d] != 0) && flip;
    logic ferr = 1'b0;
    for (int s = 0; s < cfg_stop[d]; s++) if (!stops[s]) ferr = 1'b1;
    return {perr, ferr, data & mask};
  endfunction

  // driver: one complete frame in config d; glitch_bit >= 0 inverts one cycle at that data bit's middle
  task automatic send_frame(input int d, input logic [8:0] data, input logic flip,
                            input logic [1:0] stops, input int glitch_bit);
    hold(1'b0, CM);
    for (int i = 0; i < cfg_bits[d]; i++) begin
      if (i == glitch_bit) begin
        hold(data[i], MIDP);
        hold(~data[i], 1);
        hold(data[i], CM - MIDP - 1);
      end else begin
        hold(data[i], CM);
      end
    end
    if (cfg_par[d] != 0) hold(correct_par(d, data) ^ flip, CM);
    for (int s = 0; s < cfg_stop[d]; s++) hold(stops[s], CM);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    line = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // scoreboard drain: wait (bounded) for the expected words, compare in order, then flag extras
  task automatic drain(input string name);
    int t = 0;
    logic [10:0] e;
    while ((got_q.size() - got_rd) < exp_q.size() && t < 4 * CM) begin
      @(negedge clk);
      t++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_rd < got_q.size()) begin
        chk(name, 32'(got_q[got_rd]), 32'(e));
        got_rd++;
      end else begin
        n_cmp++;
        n_err++;
        $display("FAIL %s: no word delivered, expected 0x%0h", name, e);
      end
    end
    chk({name, "_extra"}, 32'(got_q.size() - got_rd), 32'd0);
    got_rd = got_q.size();
  endtask

  typedef struct {
    int          dut;
    logic [8:0]  data;
    logic        flip;
    logic [1:0]  stops;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int v0;
    int o0;
    logic [8:0] rd;
    logic rf;
    logic [1:0] rs;

    vecs[0]  = '{0, 9'h000, 1'b0, 2'b11, 11'h000};
    vecs[1]  = '{0, 9'h0FF, 1'b0, 2'b11, 11'h0FF};
    vecs[2]  = '{0, 9'h080, 1'b0, 2'b10, 11'h280};
    vecs[3]  = '{1, 9'h041, 1'b0, 2'b11, 11'h041};
    vecs[4]  = '{1, 9'h041, 1'b1, 2'b11, 11'h441};
    vecs[5]  = '{1, 9'h07F, 1'b0, 2'b11, 11'h07F};
    vecs[6]  = '{1, 9'h000, 1'b1, 2'b11, 11'h400};
    vecs[7]  = '{2, 9'h03C, 1'b0, 2'b01, 11'h23C};
    vecs[8]  = '{2, 9'h1FF, 1'b0, 2'b11, 11'h1FF};
    vecs[9]  = '{2, 9'h155, 1'b1, 2'b11, 11'h555};
    vecs[10] = '{2, 9'h000, 1'b0, 2'b10, 11'h200};

    // reset state
    repeat (3) @(negedge clk);
    chk("reset_a", 32'({a_valid, a_perr, a_ferr, a_ovr, a_busy, a_data}), 32'd0);
    chk("reset_b", 32'({b_valid, b_perr, b_ferr, b_ovr, b_busy, b_data}), 32'd0);
    chk("reset_c", 32'({c_valid, c_perr, c_ferr, c_ovr, c_busy, c_data}), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_after_reset", 32'({a_busy, b_busy, c_busy}), 32'd0);

    // table-driven single frames
    foreach (vecs[i]) begin
      do_reset();
      sel = vecs[i].dut;
      send_frame(vecs[i].dut, vecs[i].data, vecs[i].flip, vecs[i].stops, -1);
      hold(1'b1, 6);
      exp_q.push_back(vecs[i].exp);
      drain($sformatf("vec%0d", i));
    end

    // 8N1 back-to-back 0x55, 0xA3
    do_reset();
    sel = 0;
    v0 = valid_a_cnt;
    send_frame(0, 9'h055, 1'b0, 2'b11, -1);
    send_frame(0, 9'h0A3, 1'b0, 2'b11, -1);
    hold(1'b1, 4);
    exp_q.push_back(11'h055);
    exp_q.push_back(11'h0A3);
    drain("b2b");
    chk("b2b_valid_cycles", 32'(valid_a_cnt - v0), 32'd2);

    // short low pulse on an idle line: false start, no output
    do_reset();
    sel = 0;
    v0 = valid_a_cnt;
    hold(1'b0, 10);
    hold(1'b1, 2);
    chk("glitch_busy_rise", 32'(a_busy), 32'd1);
    hold(1'b1, 2 * CM);
    chk("glitch_busy_fall", 32'(a_busy), 32'd0);
    chk("glitch_no_valid", 32'(valid_a_cnt - v0), 32'd0);

    // one-cycle glitch in data bit 3 of 0x00 is voted out
    send_frame(0, 9'h000, 1'b0, 2'b11, 3);
    hold(1'b1, 4);
    exp_q.push_back(11'h000);
    drain("vote");

    // overrun: consumer stalled, second frame dropped
    do_reset();
    sel = -1;
    ready = 1'b0;
    o0 = ovr_a;
    send_frame(0, 9'h011, 1'b0, 2'b11, -1);
    hold(1'b1, 4);
    send_frame(0, 9'h022, 1'b0, 2'b11, -1);
    hold(1'b1, 4);
    chk("ovr_valid_held", 32'(a_valid), 32'd1);
    chk("ovr_data_held", 32'(a_data), 32'h11);
    chk("ovr_flags", 32'({a_perr, a_ferr}), 32'd0);
    chk("ovr_pulses", 32'(ovr_a - o0), 32'd1);
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    chk("accept_drops_valid", 32'(a_valid), 32'd0);

    // 2 stop bits, second stop low, then a long break
    do_reset();
    sel = 2;
    send_frame(2, 9'h03C, 1'b0, 2'b01, -1);
    hold(1'b0, 5 * CM);
    chk("break_busy", 32'(c_busy), 32'd1);
    hold(1'b1, 10);
    chk("break_end_idle", 32'(c_busy), 32'd0);
    exp_q.push_back(11'h23C);
    drain("break");
    send_frame(2, 9'h0A5, 1'b0, 2'b11, -1);
    hold(1'b1, 4);
    exp_q.push_back(11'h0A5);
    drain("after_break");

    // reset in the middle of a frame, with a held word on the output
    do_reset();
    sel = -1;
    ready = 1'b0;
    send_frame(0, 9'h05A, 1'b0, 2'b11, -1);
    hold(1'b1, 4);
    chk("pre_reset_valid", 32'(a_valid), 32'd1);
    fork
      send_frame(0, 9'h0FF, 1'b0, 2'b11, -1);
      begin
        repeat (5 * CM + MIDP) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midframe_reset", 32'({a_valid, a_perr, a_ferr, a_ovr, a_busy, a_data}), 32'd0);
      end
    join
    rst_n = 1'b1;
    hold(1'b1, 4);
    ready = 1'b1;
    sel = 0;
    send_frame(0, 9'h07E, 1'b0, 2'b11, -1);
    hold(1'b1, 4);
    exp_q.push_back(11'h07E);
    drain("post_reset");

    // randomized frames on each configuration against the reference model
    for (int d = 0; d < 3; d++) begin
      do_reset();
      sel = d;
      for (int k = 0; k < 10; k++) begin
        rd = 9'($urandom_range(0, (1 << cfg_bits[d]) - 1));
        rf = 1'($urandom_range(0, 1));
        rs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
        send_frame(d, rd, rf, rs, -1);
        hold(1'b1, $urandom_range(2, 8));
        exp_q.push_back(model(d, rd, rf, rs));
      end
      hold(1'b1, 4);
      drain($sformatf("rand_cfg%0d", d));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // watchdog
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
